// File: rtl/yarp_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped, tagged table of 2-bit saturating
// counters with a registered lookup and execute-stage training/mispredict stats.
module yarp_branch_predictor #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pred_req_i,
   input  logic [31:0]      pred_pc_i,
   output logic             pred_valid_o,
   output logic             pred_taken_o,
   output logic [31:0]      pred_target_o,
   input  logic             upd_valid_i,
   input  logic [31:0]      upd_pc_i,
   input  logic             upd_taken_i,
   input  logic [31:0]      upd_target_i,
   input  logic             upd_pred_taken_i,
   output logic             mispredict_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam int unsigned TAG_W   = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   logic               pred_valid_q, pred_valid_d;
   logic               pred_taken_q, pred_taken_d;
   logic [31:0]        pred_target_q, pred_target_d;
   logic               mispredict_q, mispredict_d;
   logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0]   lk_idx, up_idx;
   logic [TAG_W-1:0]   lk_tag, up_tag;
   logic               lk_hit, up_hit;
   logic               unused_pc_bits;

   assign lk_idx = pred_pc_i[IDX_W+1:2];
   assign lk_tag = pred_pc_i[31:IDX_W+2];
   assign up_idx = upd_pc_i[IDX_W+1:2];
   assign up_tag = upd_pc_i[31:IDX_W+2];
   assign unused_pc_bits = ^{pred_pc_i[1:0], upd_pc_i[1:0]};

   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Lookup reads only the registered table, so a same-cycle update is not bypassed.
   always_comb begin
      pred_valid_d  = pred_req_i;
      pred_taken_d  = pred_req_i && lk_hit && ctr_q[lk_idx][1];
      pred_target_d = pred_taken_d ? target_q[lk_idx] : '0;
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_valid_i) begin
         if (up_hit) begin
            if (upd_taken_i) begin
               target_d[up_idx] = upd_target_i;
               if (ctr_q[up_idx] != 2'b11) begin
                  ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
               end
            end else if (ctr_q[up_idx] != 2'b00) begin
               ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
            end
         end else if (upd_taken_i) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target_i;
            ctr_d[up_idx]    = 2'b10;
         end
      end
   end

   always_comb begin
      mispredict_d  = upd_valid_i && (upd_taken_i != upd_pred_taken_i);
      mispred_cnt_d = mispred_cnt_q;
      if (mispredict_d && (mispred_cnt_q != '1)) begin
         mispred_cnt_d = mispred_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q       <= '0;
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         mispredict_q  <= 1'b0;
         mispred_cnt_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         ctr_q         <= ctr_d;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         mispredict_q  <= mispredict_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign pred_target_o = pred_target_q;
   assign mispredict_o  = mispredict_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_yarp_branch_predictor.sv
// Table-driven scoreboard bench for yarp_branch_predictor; a second instance with
// a 2-bit mispredict counter shares the stimulus to exercise counter saturation.
module tb_yarp_branch_predictor;

   logic        clk;
   logic        reset_n;
   logic        pred_req_i;
   logic [31:0] pred_pc_i;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;

   logic        pred_valid_o, pred_taken_o, mispredict_o;
   logic [31:0] pred_target_o;
   logic [15:0] mispred_cnt_o;

   logic        s_valid, s_taken, s_mispred;
   logic [31:0] s_target;
   logic [1:0]  s_cnt;

   yarp_branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
      .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
      .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
      .mispredict_o(mispredict_o), .mispred_cnt_o(mispred_cnt_o)
   );

   yarp_branch_predictor #(.IDX_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset_n(reset_n),
      .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
      .pred_valid_o(s_valid), .pred_taken_o(s_taken), .pred_target_o(s_target),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
      .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
      .mispredict_o(s_mispred), .mispred_cnt_o(s_cnt)
   );

   typedef struct {
      logic        req;
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic        ev;
      logic        et;
      logic [31:0] etgt;
      logic        em;
      int unsigned ecnt;
   } vec_t;

   typedef struct {
      int          row;
      logic        ev;
      logic        et;
      logic [31:0] etgt;
      logic        em;
      int unsigned ecnt;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic vec_t mk(input logic req, input logic [31:0] pc,
                               input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic upt,
                               input logic ev, input logic et, input logic [31:0] etgt,
                               input logic em, input int unsigned ecnt);
      vec_t v;
      v.req = req; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
      v.upt = upt; v.ev = ev; v.et = et; v.etgt = etgt; v.em = em; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      pred_req_i = 1'b0; pred_pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0;
      upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
   endtask

   // Drive one cycle of stimulus, queue its expected response, compare after the edge.
   task automatic step(input int row, input vec_t v);
      exp_t e;
      int unsigned sat;
      pred_req_i = v.req; pred_pc_i = v.pc;
      upd_valid_i = v.uv; upd_pc_i = v.upc; upd_taken_i = v.ut;
      upd_target_i = v.utgt; upd_pred_taken_i = v.upt;
      e.row = row; e.ev = v.ev; e.et = v.et; e.etgt = v.etgt; e.em = v.em; e.ecnt = v.ecnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      sat = (e.ecnt > 3) ? 3 : e.ecnt;
      chk($sformatf("row%0d pred_valid", e.row), {31'd0, pred_valid_o}, {31'd0, e.ev});
      chk($sformatf("row%0d pred_taken", e.row), {31'd0, pred_taken_o}, {31'd0, e.et});
      chk($sformatf("row%0d pred_target", e.row), pred_target_o, e.etgt);
      chk($sformatf("row%0d mispredict", e.row), {31'd0, mispredict_o}, {31'd0, e.em});
      chk($sformatf("row%0d mispred_cnt", e.row), {16'd0, mispred_cnt_o}, e.ecnt);
      chk($sformatf("row%0d sat_cnt", e.row), {30'd0, s_cnt}, sat);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " pred_valid"}, {31'd0, pred_valid_o}, 32'd0);
      chk({tag, " pred_taken"}, {31'd0, pred_taken_o}, 32'd0);
      chk({tag, " pred_target"}, pred_target_o, 32'd0);
      chk({tag, " mispredict"}, {31'd0, mispredict_o}, 32'd0);
      chk({tag, " mispred_cnt"}, {16'd0, mispred_cnt_o}, 32'd0);
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Five mispredicted taken updates bring the count to 5, then leave a lookup response live.
      for (int i = 1; i <= 5; i++) begin
         step(100 + i, mk(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0,
                          1'b0, 1'b0, 32'h0, 1'b1, i));
      end
      step(106, mk(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b1, 32'h80, 1'b0, 5));
      pred_req_i = 1'b1; pred_pc_i = 32'h100;
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      step(107, mk(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b0, 32'h0, 1'b0, 0));

      //          req  pc          uv   upc         ut   utgt        upt    ev   et   etgt        em  cnt
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 0, 32'h0,   0, 0));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 1, 32'h80,  0,   0, 0, 32'h0,   1, 1));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h80,  0, 1));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 1, 32'h80,  1,   0, 0, 32'h0,   0, 1));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 1, 32'h80,  1,   0, 0, 32'h0,   0, 1));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h80,  0, 1));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 0, 32'h0,   1,   0, 0, 32'h0,   1, 2));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 0, 32'h0,   1,   0, 0, 32'h0,   1, 3));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 0, 32'h0,   0, 3));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 0, 32'h0,   0,   0, 0, 32'h0,   0, 3));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 0, 32'h0,   0,   0, 0, 32'h0,   0, 3));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 1, 32'h90,  0,   0, 0, 32'h0,   1, 4));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 0, 32'h0,   0, 4));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 1, 32'hA0,  0,   0, 0, 32'h0,   1, 5));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'hA0,  0, 5));
      vecs.push_back(mk(0, 32'h0,   1, 32'h100, 0, 32'h0,   1,   0, 0, 32'h0,   1, 6));
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 1, 32'hB0,  0,   1, 0, 32'h0,   1, 7));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'hB0,  0, 7));
      vecs.push_back(mk(0, 32'h0,   1, 32'h140, 1, 32'h200, 0,   0, 0, 32'h0,   1, 8));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0,   1, 0, 32'h0,   0, 8));
      vecs.push_back(mk(1, 32'h140, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h200, 0, 8));
      vecs.push_back(mk(0, 32'h0,   1, 32'h180, 0, 32'h0,   0,   0, 0, 32'h0,   0, 8));
      vecs.push_back(mk(1, 32'h140, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h200, 0, 8));
      vecs.push_back(mk(0, 32'h0,   1, 32'h104, 1, 32'h300, 1,   0, 0, 32'h0,   0, 8));
      vecs.push_back(mk(1, 32'h104, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h300, 0, 8));
      vecs.push_back(mk(1, 32'h140, 0, 32'h0,   0, 32'h0,   0,   1, 1, 32'h200, 0, 8));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0,   0, 0, 32'h0,   0, 8));

      foreach (vecs[i]) begin
         step(i, vecs[i]);
      end

      idle_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
